cpu_fabric_ci_port: RTL

//  CPU-side end of the west-edge CPU<->fabric I/O column. Accepts a custom-instruction request (two 32-bit operands),

---
 rtl/fabric_ci_pkg.sv | 11 +
 rtl/cpu_fabric_ci_port_ci_cycle_counter.sv | 28 ++
 rtl/cpu_fabric_ci_port.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fabric_ci_pkg.sv
// Shared types for the CPU<->fabric custom-instruction port.
package fabric_ci_pkg;
  localparam int BITS_PER_ROW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MIN,
    WAIT_DONE,
    RESP
  } state_t;
endpackage

// File: rtl/cpu_fabric_ci_port_ci_cycle_counter.sv
// Loadable up-counter that parks on its terminal value instead of wrapping.
module ci_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         at_term
);
  logic [W-1:0] count_reg;

  assign count   = count_reg;
  assign at_term = (count_reg == term_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && !at_term) begin
      count_reg <= count_reg + W'(1);
    end
  end
endmodule

// File: rtl/cpu_fabric_ci_port.sv
// CPU-side end of the west-edge I/O column: drives operands to the fabric, waits
// for a fixed latency or a done flag (with timeout), and returns RES0..RES2.
module cpu_fabric_ci_port
  import fabric_ci_pkg::*;
#(
  parameter int NumRows        = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int LAT_W          = 4
) (
  input  logic                           UserCLK,
  input  logic                           reset,
  input  logic                           ci_valid,
  output logic                           ci_ready,
  input  logic [BITS_PER_ROW*NumRows-1:0] ci_rs1,
  input  logic [BITS_PER_ROW*NumRows-1:0] ci_rs2,
  input  logic                           cfg_mode,
  input  logic [LAT_W-1:0]               cfg_latency,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [BITS_PER_ROW*NumRows-1:0] rsp_data,
  output logic [BITS_PER_ROW*NumRows-1:0] rsp_data_hi,
  output logic [BITS_PER_ROW*NumRows-1:0] rsp_flags,
  output logic                           rsp_timeout,
  output logic [BITS_PER_ROW*NumRows-1:0] OPA,
  output logic [BITS_PER_ROW*NumRows-1:0] OPB,
  input  logic [BITS_PER_ROW*NumRows-1:0] RES0,
  input  logic [BITS_PER_ROW*NumRows-1:0] RES1,
  input  logic [BITS_PER_ROW*NumRows-1:0] RES2
);
  localparam int BUS_W  = BITS_PER_ROW * NumRows;
  localparam int CNT_W  = LAT_W + 1;
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t             state_reg;
  logic               mode_reg;
  logic [CNT_W-1:0]   lat_reg;
  logic [BUS_W-1:0]   opa_reg, opb_reg;
  logic [BUS_W-1:0]   res0_reg, res1_reg, res2_reg;
  logic               timeout_reg;

  logic               accept, done, min_hit;
  logic [CNT_W-1:0]   cnt_value;
  logic [TCNT_W-1:0]  tcnt_value;
  logic               cnt_at_term, tcnt_at_term;

  assign accept  = ci_valid && (state_reg == IDLE);
  assign done    = RES2[0];
  assign min_hit = (state_reg == WAIT_MIN) && cnt_at_term;

  // cnt starts at 1 on the accept edge so completion lands exactly L edges later.
  ci_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk      (UserCLK),
    .rst      (reset),
    .load     (accept),
    .load_val (CNT_W'(1)),
    .en       (state_reg == WAIT_MIN),
    .term_val (lat_reg),
    .count    (cnt_value),
    .at_term  (cnt_at_term)
  );

  // Terminal is one below the limit: tcnt is 0 on the first WAIT_DONE cycle.
  ci_cycle_counter #(.W(TCNT_W)) u_tcnt (
    .clk      (UserCLK),
    .rst      (reset),
    .load     (min_hit),
    .load_val ('0),
    .en       (state_reg == WAIT_DONE),
    .term_val (TCNT_W'(TIMEOUT_CYCLES - 1)),
    .count    (tcnt_value),
    .at_term  (tcnt_at_term)
  );

  always_ff @(posedge UserCLK or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      mode_reg    <= 1'b0;
      lat_reg     <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      res0_reg    <= '0;
      res1_reg    <= '0;
      res2_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (ci_valid) begin
            opa_reg   <= ci_rs1;
            opb_reg   <= ci_rs2;
            mode_reg  <= cfg_mode;
            lat_reg   <= (cfg_latency == '0) ? CNT_W'(1) : {1'b0, cfg_latency};
            state_reg <= WAIT_MIN;
          end
        end
        WAIT_MIN: begin
          if (cnt_at_term) begin
            if (!mode_reg || done) begin
              res0_reg    <= RES0;
              res1_reg    <= RES1;
              res2_reg    <= RES2;
              timeout_reg <= 1'b0;
              state_reg   <= RESP;
            end else begin
              state_reg <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          // A done flag on the terminal cycle still counts as a normal completion.
          if (done || tcnt_at_term) begin
            res0_reg    <= RES0;
            res1_reg    <= RES1;
            res2_reg    <= RES2;
            timeout_reg <= !done;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            timeout_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ci_ready    = (state_reg == IDLE);
  assign rsp_valid   = (state_reg == RESP);
  assign rsp_data    = res0_reg;
  assign rsp_data_hi = res1_reg;
  assign rsp_flags   = res2_reg;
  assign rsp_timeout = timeout_reg;

  for (genvar gi = 0; gi < NumRows; gi++) begin : g_row
    assign OPA[gi*BITS_PER_ROW +: BITS_PER_ROW] = opa_reg[gi*BITS_PER_ROW +: BITS_PER_ROW];
    assign OPB[gi*BITS_PER_ROW +: BITS_PER_ROW] = opb_reg[gi*BITS_PER_ROW +: BITS_PER_ROW];
  end
endmodule
